wptr_full: RTL and testbench

- Write-domain pointer and full-flag generator for the async FIFO; the write-side counterpart of the read-pointer/empty logic.
- Keeps a binary/Gray write pointer pair of ADDSIZE+1 bits and drives the binary memory write address.
- Exports the Gray pointer for synchronisation into the read domain.
- Compares its next Gray pointer with the read pointer, already synchronised into the write domain, to produce a registered full flag, an occupancy count and a sticky overflow error.

---
 rtl/wptr_full.sv | 80 ++++++++
 tb/tb_wptr_full.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-domain pointer, full flag, occupancy and overflow logic for an async FIFO.
// Optional almost_full output is enabled by defining FIFO_AFULL_EN.
module wptr_full #(
    parameter int ADDSIZE      = 4,
    parameter int AFULL_THRESH = 14
) (
    input  logic               clk_wr,
    input  logic               rstn,
    input  logic               wr_req,
    input  logic [ADDSIZE:0]   wq2_rptr,
    input  logic               ovf_clr,
    output logic               wen,
    output logic [ADDSIZE-1:0] waddr,
    output logic [ADDSIZE:0]   wptr,
    output logic               full,
    output logic [ADDSIZE:0]   wcount,
`ifdef FIFO_AFULL_EN
    output logic               almost_full,
`endif
    output logic               overflow
);

    localparam int PW = ADDSIZE + 1;

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rptr_full;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_count_next;
    logic          w_full_next;

    // Gating with rstn keeps the memory from seeing a write while reset is held.
    assign wen          = rstn & wr_req & ~full;
    assign waddr        = r_wbin[ADDSIZE-1:0];
    assign w_wbin_next  = r_wbin + {{ADDSIZE{1'b0}}, wen};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign w_rptr_full  = {~wq2_rptr[ADDSIZE:ADDSIZE-1], wq2_rptr[ADDSIZE-2:0]};
    assign w_full_next  = (w_wgray_next == w_rptr_full);

    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign w_count_next = w_wbin_next - w_rbin;

    always_ff @(posedge clk_wr or negedge rstn) begin
        if (!rstn) begin
            r_wbin   <= '0;
            wptr     <= '0;
            full     <= 1'b0;
            wcount   <= '0;
            overflow <= 1'b0;
        end else begin
            r_wbin <= w_wbin_next;
            wptr   <= w_wgray_next;
            full   <= w_full_next;
            wcount <= w_count_next;
            if (wr_req && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

`ifdef FIFO_AFULL_EN
    always_ff @(posedge clk_wr or negedge rstn) begin
        if (!rstn)
            almost_full <= 1'b0;
        else
            almost_full <= (w_count_next >= PW'(AFULL_THRESH));
    end
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: an occupancy-level model checked every cycle,
// plus literal expectations at the milestones of each scenario.
module tb_wptr_full;

    logic       clk_wr = 1'b0;
    logic       rstn   = 1'b0;
    logic       wr_req = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [4:0] wq2_rptr;
    logic       wen, full, overflow;
    logic [3:0] waddr;
    logic [4:0] wptr, wcount;
`ifdef FIFO_AFULL_EN
    logic       almost_full;
`endif

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    assign wq2_rptr = gray(rd_cnt);

    wptr_full dut (
        .clk_wr(clk_wr), .rstn(rstn), .wr_req(wr_req), .wq2_rptr(wq2_rptr),
        .ovf_clr(ovf_clr), .wen(wen), .waddr(waddr), .wptr(wptr), .full(full),
        .wcount(wcount),
`ifdef FIFO_AFULL_EN
        .almost_full(almost_full),
`endif
        .overflow(overflow)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count of accepted writes vs read count, both modulo 32.
    int  m_w = 0, m_cnt = 0;
    bit  m_full = 0, m_ovf = 0, m_af = 0;
    int  t_nw, t_cnt;

    always @(posedge clk_wr or negedge rstn) begin
        if (!rstn) begin
            m_w <= 0; m_cnt <= 0; m_full <= 0; m_ovf <= 0; m_af <= 0;
        end else begin
            t_nw  = (m_w + ((wr_req && !m_full) ? 1 : 0)) % 32;
            t_cnt = (t_nw - rd_cnt + 64) % 32;
            m_w    <= t_nw;
            m_cnt  <= t_cnt;
            m_full <= (t_cnt == 16);
            m_af   <= (t_cnt >= 14);
            if (wr_req && m_full) m_ovf <= 1;
            else if (ovf_clr)     m_ovf <= 0;
        end
    end

    always @(negedge clk_wr) begin
        chk("wen", wen, (rstn && wr_req && !m_full) ? 1 : 0);
        chk("waddr", waddr, m_w % 16);
        chk("wptr", wptr, gray(m_w));
        chk("full", full, m_full);
        chk("wcount", wcount, m_cnt);
        chk("overflow", overflow, m_ovf);
`ifdef FIFO_AFULL_EN
        chk("almost_full", almost_full, m_af);
`endif
    end

    task automatic tick();
        @(posedge clk_wr);
        #2;
    endtask

    task automatic do_reset();
        rstn = 0; wr_req = 0; ovf_clr = 0; rd_cnt = 0;
        tick();
        rstn = 1;
    endtask

    logic [4:0] prev;
    int tw;

    initial begin
        // Reset with a pending request.
        rstn = 0; wr_req = 1; rd_cnt = 0;
        tick(); tick();
        chk("rst_wen", wen, 0);
        chk("rst_wptr", wptr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_full", full, 0);
        chk("rst_wcount", wcount, 0);
        chk("rst_overflow", overflow, 0);
        rstn = 1;
        #1 chk("first_waddr", waddr, 0);
        chk("first_wen", wen, 1);

        // Fill 16 locations.
        for (int i = 0; i < 16; i++) begin
            chk("fill_waddr", waddr, i);
            tick();
            chk("fill_wcount", wcount, i + 1);
        end
        chk("fill_full", full, 1);
        chk("fill_wptr", wptr, 5'b11000);
        chk("fill_waddr_wrap", waddr, 0);
        chk("fill_wen", wen, 0);

        // Overflow while full.
        for (int i = 0; i < 3; i++) tick();
        chk("ovf_wptr", wptr, 5'b11000);
        chk("ovf_set", overflow, 1);
        ovf_clr = 1; tick();
        chk("ovf_set_wins", overflow, 1);
        wr_req = 0; tick();
        chk("ovf_cleared", overflow, 0);
        ovf_clr = 0;

        // Read pointer advances by one, then refill.
        rd_cnt = 1; tick();
        chk("drain_full", full, 0);
        chk("drain_wcount", wcount, 15);
        wr_req = 1; tick();
        wr_req = 0;
        chk("refill_full", full, 1);
        chk("refill_wptr", wptr, 5'b11001);

        // Pointer wrap with reader trailing by 3.
        do_reset();
        wr_req = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("wrap_pre_cnt", wcount, 3);
        tw = 3;
        for (int i = 0; i < 40; i++) begin
            prev = wptr;
            rd_cnt = (tw + 1 - 3) % 32;
            tick();
            tw++;
            chk("wrap_hamming", $countones(prev ^ wptr), 1);
            chk("wrap_nofull", full, 0);
        end
        chk("wrap_wcount", wcount, 3);
        chk("wrap_wptr", wptr, gray(43));
        wr_req = 0;

        // Burst to 14 then asynchronous reset.
        do_reset();
        wr_req = 1;
        for (int i = 0; i < 13; i++) tick();
        chk("burst_cnt13", wcount, 13);
`ifdef FIFO_AFULL_EN
        chk("af_below", almost_full, 0);
`endif
        tick();
        chk("burst_cnt14", wcount, 14);
`ifdef FIFO_AFULL_EN
        chk("af_at_thresh", almost_full, 1);
`endif
        tick();
        rstn = 0;
        #1;
        chk("arst_wptr", wptr, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_wcount", wcount, 0);
        chk("arst_full", full, 0);
        chk("arst_wen", wen, 0);
        chk("arst_overflow", overflow, 0);
`ifdef FIFO_AFULL_EN
        chk("arst_af", almost_full, 0);
`endif
        wr_req = 0;
        tick();
        rstn = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
